// File: rtl/flick_debounce_if.sv
// Push-button debouncer bundle: raw button in, debounced level and event pulses out.
// master = button/consumer side, slave = the debouncer itself.
interface flick_debounce_if;
    logic btn_raw;
    logic flick;
    logic flick_rise;
    logic flick_fall;
    logic long_press;

    modport master (
        output btn_raw,
        input  flick,
        input  flick_rise,
        input  flick_fall,
        input  long_press
    );

    modport slave (
        input  btn_raw,
        output flick,
        output flick_rise,
        output flick_fall,
        output long_press
    );
endinterface

// File: rtl/flick_debounce.sv
// Push-button debouncer: 2-flop sync, 4-state debounce FSM, press/release pulses, optional long-press
// (FLICK_LONG_PRESS_EN). flick follows btn_raw DEB_MAX+2 edges after first sampling; no backpressure.
module flick_debounce #(
    parameter int CNT_W    = 20,
    parameter int DEB_MAX  = 500000,
    parameter int LONG_MAX = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    flick_debounce_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_MAX - 1);

    if (DEB_MAX < 2 || DEB_MAX > (2 ** CNT_W) - 1 ||
        LONG_MAX < 2 || LONG_MAX > (2 ** CNT_W) - 1) begin : g_bad_cfg
        $error("flick_debounce: DEB_MAX/LONG_MAX outside 2..2^CNT_W-1");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s2_q;
    logic             flick_q, flick_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every transition restarts cnt; the terminal compare keeps it from ever wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!s2_q) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (s2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        flick_d = (state_d == HELD) || (state_d == REL_CHK);
        rise_d  = (state_q == PRESS_CHK) && (state_d == HELD);
        fall_d  = (state_q == REL_CHK) && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            flick_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= bus.btn_raw;
            s2_q    <= s1_q;
            flick_q <= flick_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign bus.flick      = flick_q;
    assign bus.flick_rise = rise_q;
    assign bus.flick_fall = fall_q;

`ifdef FLICK_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_MAX);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             long_q, long_d;

    // Only a fresh press clears the hold count, so a release bounce cannot re-arm long_press.
    always_comb begin
        hold_d = hold_q;
        if (state_q == IDLE || rise_d) begin
            hold_d = '0;
        end else if ((state_q == HELD || state_q == REL_CHK) && hold_q != LONG_LIM) begin
            hold_d = hold_q + 1'b1;
        end
        long_d = (hold_d == LONG_LIM) && (hold_q != LONG_LIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign bus.long_press = long_q;
`else
    assign bus.long_press = 1'b0;
`endif

endmodule

// File: doc/flick_debounce.md
FLICK_DEBOUNCE -- requirements
Module: flick_debounce

Interface
REQ-001 SHALL provide parameter CNT_W, default 20: width of the debounce and long-press counters.
REQ-002 SHALL provide parameter DEB_MAX, default 500000: number of stable cycles to accept an edge (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
REQ-003 SHALL provide parameter LONG_MAX, default 1000000: number of held cycles that qualify a long press; legal range 2..2^CNT_W-1.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, rising-edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 btn_raw  input  1  asynchronous, bouncing push-button level, 1 = pressed.
REQ-008 flick  output  1  debounced level, 1 = pressed; feeds the LED pattern FSM flick input.
REQ-009 flick_rise  output  1  one-cycle pulse on accepted press.
REQ-010 flick_fall  output  1  one-cycle pulse on accepted release.
REQ-011 long_press  output  1  one-cycle pulse when a press has been held LONG_MAX cycles.

Function
REQ-012 SHALL pass btn_raw through a two-flop synchronizer (s1, s2); only s2 is used downstream.
REQ-013 SHALL implement a 4-state FSM: IDLE, PRESS_CHK, HELD, REL_CHK.
REQ-014 IDLE: s2=1 -> PRESS_CHK with cnt=0; else stay.
REQ-015 PRESS_CHK: s2=0 -> IDLE, no output change (bounce rejected); cnt=DEB_MAX-1 with s2=1 -> HELD; else cnt+1.
REQ-016 HELD: s2=0 -> REL_CHK with cnt=0; else stay.
REQ-017 REL_CHK: s2=1 -> HELD, no pulse; cnt=DEB_MAX-1 with s2=0 -> IDLE; else cnt+1.
REQ-018 flick SHALL be registered, 1 exactly in HELD and REL_CHK.
REQ-019 flick_rise SHALL be 1 for exactly the first cycle flick=1 after IDLE/PRESS_CHK; flick_fall SHALL be 1 for exactly the first cycle flick=0 after REL_CHK.
REQ-020 Latency: with btn_raw stable, flick changes DEB_MAX+2 edges after the edge that first samples the new btn_raw value into s1.
REQ-021 Any glitch shorter than DEB_MAX cycles at s2 SHALL produce no change on any output.
REQ-022 flick_rise and flick_fall SHALL never be 1 in the same cycle; at most one pulse per accepted edge.
REQ-023 Counters SHALL never wrap; cnt is reset to 0 on every state entry.

Reset
REQ-024 On reset=1 at a clk edge: s1, s2, cnt, hold counter = 0; state = IDLE; flick, flick_rise, flick_fall, long_press = 0.
REQ-025 Reset mid-operation (any state) SHALL abort without emitting pulses; if btn_raw is still 1 after reset release, the press SHALL be re-accepted via full debounce, giving a new flick_rise.
REQ-026 Reset SHALL take priority over all other events in the same cycle.

Configuration
REQ-027 Macro FLICK_LONG_PRESS_EN defined: a CNT_W-bit hold counter SHALL clear on HELD entry, increment in HELD and REL_CHK, saturate at LONG_MAX, and pulse long_press for one cycle when it reaches LONG_MAX; at most once per press; cleared in IDLE.
REQ-028 Macro FLICK_LONG_PRESS_EN undefined: hold counter SHALL be absent, long_press tied to 0; all other behaviour identical.

Verification (DEB_MAX=4, LONG_MAX=10, CNT_W=8)
REQ-029 Reset, btn_raw=0 for 20 cycles -> all outputs 0, state IDLE.
REQ-030 btn_raw 0->1 held -> flick=1 and flick_rise=1 for one cycle at edge 6 after first sampling; flick_rise=0 thereafter.
REQ-031 btn_raw pulses 1 for 3 cycles, then 0 -> flick, flick_rise, flick_fall stay 0 throughout.
REQ-032 Accepted press, then btn_raw 0 for 2 cycles, back to 1 -> flick stays 1, no flick_fall; then release held 0 -> flick_fall one cycle, flick=0 six edges after release sampled.
REQ-033 With FLICK_LONG_PRESS_EN: hold 30 cycles after flick_rise -> exactly one long_press pulse, 10 cycles after flick rises; without macro -> long_press always 0.
REQ-034 Assert reset while in PRESS_CHK and again in HELD with btn_raw=1 -> no pulses during reset; after release, flick_rise re-asserts 6 edges later.
